// File: rtl/msu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msu_pkg
// Description : Shared definitions for the squaring-loop collector: controller
//               state encoding, the width of one wrapper output slot, and the
//               default normalized coefficient width.
// Revision    : 1.0 - initial release
// ============================================================================
package msu_pkg;

  // Width of one coefficient slot in the squaring wrapper output bus.
  localparam int SLOT_LEN     = 32;
  // Default normalized bits per coefficient.
  localparam int DEF_WORD_LEN = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/msu_carry_step.sv
`default_nettype none
// ============================================================================
// Module      : msu_carry_step
// Description : One step of the carry-propagating normalization. Adds the
//               incoming carry to a 32-bit slot (33-bit sum), emits the low
//               WORD_LEN bits as the normalized coefficient and the remaining
//               upper bits as the carry into the next coefficient.
// Ports       : slot      - unnormalized coefficient slot
//               carry_in  - carry from the previous coefficient
//               word      - normalized coefficient
//               carry_out - carry into the next coefficient
// Revision    : 1.0 - initial release
// ============================================================================
module msu_carry_step
  import msu_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN
) (
  input  logic [SLOT_LEN-1:0] slot,
  input  logic [SLOT_LEN:0]   carry_in,
  output logic [WORD_LEN-1:0] word,
  output logic [SLOT_LEN:0]   carry_out
);

  logic [SLOT_LEN:0] w_sum;

  // The carry never exceeds 2^(33-WORD_LEN), so a 33-bit sum cannot overflow.
  assign w_sum     = {1'b0, slot} + carry_in;
  assign word      = w_sum[WORD_LEN-1:0];
  assign carry_out = w_sum >> WORD_LEN;

endmodule
`default_nettype wire

// File: rtl/msu_sq_loop_collector.sv
`default_nettype none
// ============================================================================
// Module      : msu_sq_loop_collector
// Description : Controls a repeated-squaring run. On start it launches the
//               squaring wrapper, counts completed squarings, captures the
//               wrapper output after t_final squarings and then normalizes
//               the captured 32-bit slots into WORD_LEN-bit coefficients, one
//               coefficient per cycle with carry propagation.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               start, t_final  - run request and squaring count
//               sq_start        - one-cycle launch pulse to the wrapper
//               sq_out,sq_valid - wrapper result bus and completion pulse
//               iter_count      - squarings counted in the current run
//               result          - normalized final value
//               overflow        - carry out of the top coefficient
//               busy, done      - run/normalize in progress, run finished
// Config      : MSU_OVERFLOW_FLAG_EN - when defined, overflow reports a
//               nonzero final carry; otherwise it is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module msu_sq_loop_collector
  import msu_pkg::*;
#(
  parameter int MOD_LEN      = 1024,
  parameter int WORD_LEN     = DEF_WORD_LEN,
  parameter int NUM_ELEMENTS = MOD_LEN / WORD_LEN,
  parameter int T_LEN        = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [T_LEN-1:0]                   t_final,
  output logic                               sq_start,
  input  logic [NUM_ELEMENTS*2*WORD_LEN-1:0] sq_out,
  input  logic                               sq_valid,
  output logic [T_LEN-1:0]                   iter_count,
  output logic [MOD_LEN-1:0]                 result,
  output logic                               overflow,
  output logic                               busy,
  output logic                               done
);

  localparam int              IDX_W    = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

  state_t                             r_state;
  logic [T_LEN-1:0]                   r_t_final;
  logic [NUM_ELEMENTS*2*WORD_LEN-1:0] r_slots;
  logic [IDX_W-1:0]                   r_idx;
  logic [SLOT_LEN:0]                  r_carry;

  logic [SLOT_LEN-1:0]                w_slot;
  logic [WORD_LEN-1:0]                w_word;
  logic [SLOT_LEN:0]                  w_carry_next;
  logic [T_LEN-1:0]                   w_iter_next;

  assign w_slot      = r_slots[r_idx*SLOT_LEN +: SLOT_LEN];
  assign w_iter_next = iter_count + T_LEN'(1);

  msu_carry_step #(
    .WORD_LEN (WORD_LEN)
  ) u_carry_step (
    .slot      (w_slot),
    .carry_in  (r_carry),
    .word      (w_word),
    .carry_out (w_carry_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_t_final  <= '0;
      r_slots    <= '0;
      r_idx      <= '0;
      r_carry    <= '0;
      sq_start   <= 1'b0;
      iter_count <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef MSU_OVERFLOW_FLAG_EN
      overflow   <= 1'b0;
`endif
    end else begin
      sq_start <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // A zero-length run is meaningless and leaves the state untouched.
          // result is deliberately kept so DONE data stays readable until
          // the new run starts overwriting it in NORM.
          if (start && (t_final != '0)) begin
            r_t_final  <= t_final;
            iter_count <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            sq_start   <= 1'b1;
            r_state    <= ST_RUN;
`ifdef MSU_OVERFLOW_FLAG_EN
            overflow   <= 1'b0;
`endif
          end
        end

        ST_RUN: begin
          if (sq_valid) begin
            iter_count <= w_iter_next;
            // Leaving RUN on the matching pulse also keeps iter_count from
            // ever counting past t_final.
            if (w_iter_next == r_t_final) begin
              r_slots <= sq_out;
              r_idx   <= '0;
              r_carry <= '0;
              r_state <= ST_NORM;
            end
          end
        end

        ST_NORM: begin
          result[r_idx*WORD_LEN +: WORD_LEN] <= w_word;
          r_carry <= w_carry_next;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
`ifdef MSU_OVERFLOW_FLAG_EN
            overflow <= |w_carry_next;
`endif
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifndef MSU_OVERFLOW_FLAG_EN
  // The final carry is discarded in this build.
  assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msu_sq_loop_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_msu_sq_loop_collector
// Description : Self-checking bench for msu_sq_loop_collector. Expected results
//               are computed as the plain integer sum of slot_j * 2^(16*j) and
//               queued when the final squaring pulse is issued; a monitor pops
//               and compares on every rising edge of done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msu_sq_loop_collector;

  localparam int MOD_LEN  = 1024;
  localparam int WORD_LEN = 16;
  localparam int NE       = MOD_LEN / WORD_LEN;
  localparam int T_LEN    = 64;
  localparam int WIDE     = MOD_LEN + 64;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic [T_LEN-1:0]        t_final;
  logic                    sq_start;
  logic [NE*2*WORD_LEN-1:0] sq_out;
  logic                    sq_valid;
  logic [T_LEN-1:0]        iter_count;
  logic [MOD_LEN-1:0]      result;
  logic                    overflow;
  logic                    busy;
  logic                    done;

  msu_sq_loop_collector #(
    .MOD_LEN      (MOD_LEN),
    .WORD_LEN     (WORD_LEN),
    .NUM_ELEMENTS (NE),
    .T_LEN        (T_LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .t_final    (t_final),
    .sq_start   (sq_start),
    .sq_out     (sq_out),
    .sq_valid   (sq_valid),
    .iter_count (iter_count),
    .result     (result),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MOD_LEN-1:0] res;
    logic               ovf;
    logic [T_LEN-1:0]   iters;
    int                 last_cyc;
  } exp_t;

  exp_t               sb[$];
  int                 checks = 0;
  int                 errors = 0;
  int                 cyc = 0;
  int                 sq_start_cnt = 0;
  logic [MOD_LEN-1:0] last_res;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input logic [MOD_LEN-1:0] act, input logic [MOD_LEN-1:0] exp);
    int first;
    checks++;
    if (act !== exp) begin
      errors++;
      first = 0;
      for (int j = NE - 1; j >= 0; j--)
        if (act[j*WORD_LEN +: WORD_LEN] !== exp[j*WORD_LEN +: WORD_LEN]) first = j;
      $display("FAIL %s word %0d actual=%h expected=%h", nm, first,
               act[first*WORD_LEN +: WORD_LEN], exp[first*WORD_LEN +: WORD_LEN]);
    end
  endtask

  // Reference: normalization is just the exact integer value of the slot sum.
  task automatic model(input logic [NE*32-1:0] v, output logic [MOD_LEN-1:0] r, output logic o);
    logic [WIDE-1:0] tot;
    logic [WIDE-1:0] s;
    tot = '0;
    for (int j = 0; j < NE; j++) begin
      s = '0;
      s[31:0] = v[j*32 +: 32];
      tot = tot + (s << (WORD_LEN * j));
    end
    r = tot[MOD_LEN-1:0];
`ifdef MSU_OVERFLOW_FLAG_EN
    o = |tot[WIDE-1:MOD_LEN];
`else
    o = 1'b0;
`endif
  endtask

  // Monitor: compare every completed run against the scoreboard.
  initial begin
    logic done_d;
    exp_t e;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (sq_start === 1'b1) sq_start_cnt++;
      if (done === 1'b1 && done_d !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = sb.pop_front();
          chk_res("result", result, e.res);
          chk("overflow", 64'(overflow), 64'(e.ovf));
          chk("iter_count_done", iter_count, e.iters);
          chk("done_latency", 64'(cyc - e.last_cyc), 64'(NE + 1));
        end
      end
      done_d = done;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [T_LEN-1:0] tf);
    start   = 1'b1;
    t_final = tf;
    tick(1);
    start   = 1'b0;
  endtask

  task automatic pulse();
    sq_valid = 1'b1;
    tick(1);
    sq_valid = 1'b0;
  endtask

  // mode 0: slot j = j, mode 1: all 0x0001_FFFF, otherwise random
  task automatic fill(input int mode);
    for (int j = 0; j < NE; j++) begin
      if (mode == 0)      sq_out[j*32 +: 32] = 32'(j);
      else if (mode == 1) sq_out[j*32 +: 32] = 32'h0001_FFFF;
      else                sq_out[j*32 +: 32] = $urandom();
    end
  endtask

  task automatic run_pulses(input int tf, input int gap);
    exp_t e;
    for (int i = 0; i < tf; i++) begin
      tick(gap);
      if (i == tf - 1) begin
        model(sq_out, e.res, e.ovf);
        e.iters    = T_LEN'(tf);
        e.last_cyc = cyc;
        sb.push_back(e);
        last_res   = e.res;
      end
      pulse();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    chk("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    int s0;
    int tf;
    reset    = 1'b1;
    start    = 1'b0;
    t_final  = '0;
    sq_valid = 1'b0;
    sq_out   = '0;
    last_res = '0;
    tick(3);

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sq_start", 64'(sq_start), 64'd0);
    chk("rst_iter", iter_count, 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk_res("rst_result", result, '0);
    reset = 1'b0;
    tick(1);

    // Zero-length start is ignored
    s0 = sq_start_cnt;
    do_start(0);
    tick(5);
    chk("tf0_busy", 64'(busy), 64'd0);
    chk("tf0_sq_start_cnt", 64'(sq_start_cnt - s0), 64'd0);
    chk("tf0_done", 64'(done), 64'd0);

    // Ramp slots, three squarings ten cycles apart
    fill(0);
    s0 = sq_start_cnt;
    do_start(3);
    chk("run_sq_start", 64'(sq_start), 64'd1);
    chk("run_busy", 64'(busy), 64'd1);
    run_pulses(3, 10);
    wait_done();
    chk("ramp_sq_start_cnt", 64'(sq_start_cnt - s0), 64'd1);
    chk("ramp_busy_after", 64'(busy), 64'd0);

    // Restart from DONE: done drops, new launch, old result held until NORM
    fill(2);
    s0 = sq_start_cnt;
    do_start(2);
    chk("restart_done", 64'(done), 64'd0);
    chk("restart_sq_start", 64'(sq_start), 64'd1);
    chk("restart_iter", iter_count, 64'd0);
    chk_res("restart_result_held", result, last_res);
    begin
      logic [MOD_LEN-1:0] prior;
      prior = last_res;
      run_pulses(2, 4);
      chk_res("restart_result_held_norm", result, prior);
    end
    wait_done();
    chk("restart_sq_start_cnt", 64'(sq_start_cnt - s0), 64'd1);

    // Carry-heavy slots
    fill(1);
    do_start(1);
    run_pulses(1, 3);
    wait_done();

    // Start while busy is ignored; extra sq_valid in DONE is ignored
    fill(2);
    s0 = sq_start_cnt;
    do_start(3);
    tick(2);
    do_start(5);
    run_pulses(3, 5);
    wait_done();
    chk("busy_start_sq_start_cnt", 64'(sq_start_cnt - s0), 64'd1);
    pulse();
    tick(2);
    chk("iter_hold_done", iter_count, 64'd3);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      fill(2);
      tf = int'($urandom_range(1, 4));
      do_start(T_LEN'(tf));
      run_pulses(tf, int'($urandom_range(1, 6)));
      wait_done();
    end

    // Reset in the middle of NORM
    fill(2);
    do_start(1);
    tick(2);
    pulse();
    tick(9);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midnorm_busy", 64'(busy), 64'd0);
    chk("midnorm_done", 64'(done), 64'd0);
    chk("midnorm_iter", iter_count, 64'd0);
    chk_res("midnorm_result", result, '0);
    pulse();
    tick(3);
    pulse();
    tick(80);
    chk("midnorm_iter_after", iter_count, 64'd0);
    chk("midnorm_done_after", 64'(done), 64'd0);
    chk("midnorm_busy_after", 64'(busy), 64'd0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
